// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clk/data enables.
// Raw lines are synchronized and glitch-filtered; the FSM paces bits on filtered falling edges.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, DONE, ERR} state_t;

  state_t          r_state;
  logic [1:0]      r_s1, r_s2, r_filt;
  logic [FW-1:0]   r_fcnt [2];
  logic            r_clk_d, r_fall;
  logic [9:0]      r_frame;
  logic [IW-1:0]   r_inh;
  logic [TW-1:0]   r_wd;
  logic [3:0]      r_bit;
  logic            r_ready, r_busy, r_done, r_err, r_clk_oe, r_data_oe;
  logic [1:0]      w_raw;

  assign w_raw       = {ps2_data_in, ps2_clk_in};
  assign tx_ready    = r_ready;
  assign busy        = r_busy;
  assign tx_done     = r_done;
  assign tx_error    = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  // bit 0 = clock, bit 1 = data; both idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 2'b11;
      r_s2    <= 2'b11;
      r_filt  <= 2'b11;
      r_clk_d <= 1'b1;
      r_fall  <= 1'b0;
      for (int k = 0; k < 2; k++) r_fcnt[k] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_clk_d <= r_filt[0];
      r_fall  <= r_clk_d & ~r_filt[0];
      for (int k = 0; k < 2; k++) begin
        if (r_s2[k] == r_filt[k]) r_fcnt[k] <= '0;
        else if (r_fcnt[k] == FW'(FILTER_LEN - 1)) begin
          r_filt[k] <= r_s2[k];
          r_fcnt[k] <= '0;
        end else r_fcnt[k] <= r_fcnt[k] + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_frame   <= '0;
      r_inh     <= '0;
      r_wd      <= '0;
      r_bit     <= '0;
    end else begin
      case (r_state)
        IDLE: if (tx_valid) begin
          r_frame  <= {1'b1, ~^tx_data, tx_data};
          r_clk_oe <= 1'b1;
          r_ready  <= 1'b0;
          r_busy   <= 1'b1;
          r_inh    <= '0;
          r_state  <= INHIBIT;
        end
        INHIBIT: if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
          r_data_oe <= 1'b1;
          r_state   <= REQ;
        end else r_inh <= r_inh + IW'(1);
        REQ: begin
          r_clk_oe <= 1'b0;
          r_bit    <= '0;
          r_wd     <= '0;
          r_state  <= SEND;
        end
        SEND, ACK, RELEASE: begin
          if (r_state == RELEASE && r_filt == 2'b11) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_fall) begin
            r_wd <= '0;
            if (r_state == SEND) begin
              r_bit     <= r_bit + 4'd1;
              r_data_oe <= ~r_frame[r_bit];
              if (r_bit == 4'd9) r_state <= ACK;
            end else if (r_state == ACK) begin
              r_state   <= r_filt[1] ? ERR : RELEASE;
              r_err     <= r_filt[1];
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b0;
            end
          end else if (r_wd == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err     <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ERR;
          end else r_wd <= r_wd + TW'(1);
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        ERR: begin
          r_err     <= 1'b0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain line model and a PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
  int         n_chk = 0, n_err = 0, done_cnt = 0, err_cnt = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    done_cnt <= done_cnt + int'(tx_done);
    err_cnt  <= err_cnt + int'(tx_error);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [9:0] exp_slot, input bit ack,
                       input bit glitch_en, input bit poke, input int rst_bit);
    int n, d0, e0, ones;
    logic [9:0] slot;
    slot = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < INH + 50) begin n++; @(negedge clk); end
    chk("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 10) begin n++; @(negedge clk); end
    chk("req_len", n, 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == rst_bit) begin
        repeat (5) @(negedge clk);
        chk("pre_rst_data_oe", ps2_data_oe, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_err", err_cnt - e0, 0);
        chk("rst_ready", tx_ready, 1);
        return;
      end
      repeat (HALF) @(negedge clk);
      if (i < 10) slot[i] = ps2_data_oe;
      dev_clk_low = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        glitch = glitch_en && i == 3 && c >= 10 && c < 13;
        if (poke && i == 5 && c == 10) begin tx_data = 8'hAA; tx_valid = 1'b1; end
        if (poke && i == 5 && c == 11) begin
          chk("busy_not_ready", tx_ready, 0);
          tx_valid = 1'b0;
          tx_data  = ~d;
        end
        if (c == HALF / 2) dev_data_low = (i == 9) ? ack : 1'b0;
        @(negedge clk);
      end
    end
    repeat (60) @(negedge clk);
    ones = $countones(~slot[8:0]);
    chk("slots", slot, exp_slot);
    chk("odd_ones", ones % 2, 1);
    chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
    chk("err_pulses", err_cnt - e0, ack ? 0 : 1);
    chk("end_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("end_ready", tx_ready, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_error", tx_error, 0);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    frame(8'hED, 10'h012, 1'b1, 1'b0, 1'b0, -1);
    frame(8'hFF, 10'h000, 1'b1, 1'b0, 1'b0, -1);
    frame(8'h01, 10'h1FE, 1'b1, 1'b0, 1'b0, -1);
    frame(8'h00, 10'h0FF, 1'b1, 1'b0, 1'b0, -1);
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < INH + 50) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_error && n < TMO + 50) begin @(negedge clk); n++; end
    chk("timeout_len", n, TMO);
    @(negedge clk);
    chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("timeout_ready", tx_ready, 1);
    frame(8'hF4, 10'h10B, 1'b0, 1'b0, 1'b0, -1);
    frame(8'hF4, 10'h10B, 1'b1, 1'b0, 1'b0, 4);
    frame(8'hFF, 10'h000, 1'b1, 1'b0, 1'b0, -1);
    frame(8'h3C, 10'h0C3, 1'b1, 1'b1, 1'b1, -1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL sim_timeout: got still running, expected finished");
    $fatal(1);
  end
endmodule
